// File: rtl/segment_inserter.sv
// AXI4-Stream segment inserter: splices a fixed-size byte segment into each packet at a fixed
// byte offset, absorbing the byte shift in a carry register and emitting a flush beat when needed.
`timescale 1ns/1ps
module segment_inserter #(
    parameter int AXIS_BUS_WIDTH    = 64,
    parameter int AXIS_TUSER_WIDTH  = 4,
    parameter int MAX_PACKET_LENGTH = 1522,
    parameter int INSERT_OFFSET     = 12,
    parameter int INSERT_SIZE_BYTES = 4
) (
    input  logic                           aclk,
    input  logic                           aresetn,
    input  logic [AXIS_BUS_WIDTH-1:0]      axis_in_tdata,
    input  logic [AXIS_BUS_WIDTH/8-1:0]    axis_in_tkeep,
    input  logic [AXIS_TUSER_WIDTH-1:0]    axis_in_tuser,
    input  logic                           axis_in_tlast,
    input  logic                           axis_in_tvalid,
    output logic                           axis_in_tready,
    output logic [AXIS_BUS_WIDTH-1:0]      axis_out_tdata,
    output logic [AXIS_BUS_WIDTH/8-1:0]    axis_out_tkeep,
    output logic [AXIS_TUSER_WIDTH-1:0]    axis_out_tuser,
    output logic                           axis_out_tlast,
    output logic                           axis_out_tvalid,
    input  logic                           axis_out_tready,
    input  logic [INSERT_SIZE_BYTES*8-1:0] segment_data,
    input  logic                           segment_enable
);
    localparam int B        = AXIS_BUS_WIDTH / 8;
    localparam int S        = INSERT_SIZE_BYTES;
    localparam int INS_BEAT = INSERT_OFFSET / B;
    localparam int LANE     = INSERT_OFFSET % B;
    localparam int CW       = $clog2(MAX_PACKET_LENGTH / B + 2);
    localparam int KW       = $clog2(B + S + 1);

    localparam logic [1:0] PRE   = 2'd0;
    localparam logic [1:0] INS   = 2'd1;
    localparam logic [1:0] SHIFT = 2'd2;
    localparam logic [1:0] FLUSH = 2'd3;

    function automatic logic [KW-1:0] popcount(input logic [B-1:0] k);
        logic [KW-1:0] n;
        n = {KW{1'b0}};
        for (int i = 0; i < B; i++) n = n + {{(KW-1){1'b0}}, k[i]};
        return n;
    endfunction

    function automatic logic [B-1:0] ones(input logic [KW-1:0] n);
        logic [B-1:0] m;
        for (int i = 0; i < B; i++) m[i] = (KW'(i) < n);
        return m;
    endfunction

    logic [1:0]                  state_q, state_d;
    logic [CW-1:0]               beat_cnt_q, beat_cnt_d;
    logic [S*8-1:0]              carry_q, carry_d;
    logic [KW-1:0]               flush_cnt_q, flush_cnt_d;
    logic [S*8-1:0]              seg_q, seg_d;
    logic                        en_q, en_d;
    logic [AXIS_TUSER_WIDTH-1:0] user_q, user_d;
    logic                        rdy_en_q, rdy_en_d;
    logic [AXIS_BUS_WIDTH-1:0]   out_data_q, out_data_d;
    logic [B-1:0]                out_keep_q, out_keep_d;
    logic [AXIS_TUSER_WIDTH-1:0] out_user_q, out_user_d;
    logic                        out_last_q, out_last_d;
    logic                        out_valid_q, out_valid_d;

    logic                        load_s, in_ready_s, in_fire_s, first_s, en_s, ins_s, do_ins_s;
    logic [S*8-1:0]              seg_s;
    logic [KW-1:0]               pc_s, total_s;
    logic [(B+S)*8-1:0]          merged_s;
    logic [AXIS_BUS_WIDTH-1:0]   shifted_s, flush_data_s;

    // Handshake qualifiers and per-packet segment selection (live on the first beat, held after).
    always_comb begin
        load_s     = !out_valid_q || axis_out_tready;
        in_ready_s = rdy_en_q && load_s && (state_q != FLUSH);
        in_fire_s  = in_ready_s && axis_in_tvalid;
        first_s    = (state_q == PRE) && (beat_cnt_q == {CW{1'b0}});
        seg_s      = first_s ? segment_data : seg_q;
        en_s       = first_s ? segment_enable : en_q;
        ins_s      = (state_q == INS) || ((INS_BEAT == 0) && first_s && segment_enable);
        pc_s       = popcount(axis_in_tkeep);
        total_s    = pc_s + KW'(S);
        do_ins_s   = ins_s && (!axis_in_tlast || (pc_s > KW'(LANE)));
    end

    // Byte-lane datapaths: insertion-beat merge, steady-state shift, and flush beat.
    always_comb begin
        int src;
        merged_s     = {((B+S)*8){1'b0}};
        shifted_s    = {AXIS_BUS_WIDTH{1'b0}};
        flush_data_s = {AXIS_BUS_WIDTH{1'b0}};
        for (int i = 0; i < B + S; i++) begin
            if (i < LANE) begin
                merged_s[i*8 +: 8] = axis_in_tdata[i*8 +: 8];
            end else if (i < LANE + S) begin
                src = i - LANE;
                merged_s[i*8 +: 8] = seg_s[src*8 +: 8];
            end else begin
                src = (i >= S) ? i - S : 0;
                merged_s[i*8 +: 8] = axis_in_tdata[src*8 +: 8];
            end
        end
        for (int i = 0; i < B; i++) begin
            if (i < S) begin
                shifted_s[i*8 +: 8]    = carry_q[i*8 +: 8];
                flush_data_s[i*8 +: 8] = carry_q[i*8 +: 8];
            end else begin
                src = (i >= S) ? i - S : 0;
                shifted_s[i*8 +: 8]    = axis_in_tdata[src*8 +: 8];
                flush_data_s[i*8 +: 8] = 8'h00;
            end
        end
    end

    // Next-state logic for the FSM, carry, beat counter and output register.
    always_comb begin
        state_d     = state_q;
        beat_cnt_d  = beat_cnt_q;
        carry_d     = carry_q;
        flush_cnt_d = flush_cnt_q;
        seg_d       = seg_q;
        en_d        = en_q;
        user_d      = user_q;
        rdy_en_d    = 1'b1;
        out_data_d  = out_data_q;
        out_keep_d  = out_keep_q;
        out_user_d  = out_user_q;
        out_last_d  = out_last_q;
        out_valid_d = out_valid_q;
        if (state_q == FLUSH) begin
            if (load_s) begin
                out_data_d  = flush_data_s;
                out_keep_d  = ones(flush_cnt_q);
                out_user_d  = user_q;
                out_last_d  = 1'b1;
                out_valid_d = 1'b1;
                state_d     = PRE;
                beat_cnt_d  = {CW{1'b0}};
            end else begin
                out_valid_d = out_valid_q;
            end
        end else if (in_fire_s) begin
            out_valid_d = 1'b1;
            out_user_d  = axis_in_tuser;
            out_data_d  = axis_in_tdata;
            out_keep_d  = axis_in_tkeep;
            out_last_d  = axis_in_tlast;
            user_d      = axis_in_tuser;
            if (first_s) begin
                seg_d = segment_data;
                en_d  = segment_enable;
            end else begin
                seg_d = seg_q;
            end
            if (axis_in_tlast) begin
                beat_cnt_d = {CW{1'b0}};
            end else if (beat_cnt_q != {CW{1'b1}}) begin
                beat_cnt_d = beat_cnt_q + {{(CW-1){1'b0}}, 1'b1};
            end else begin
                beat_cnt_d = beat_cnt_q;
            end
            if (do_ins_s || (state_q == SHIFT)) begin
                // Insertion and shift beats share the same tail handling; only the data source differs.
                out_data_d = do_ins_s ? merged_s[B*8-1:0] : shifted_s;
                carry_d    = do_ins_s ? merged_s[B*8 +: S*8] : axis_in_tdata[(B-S)*8 +: S*8];
                if (!axis_in_tlast) begin
                    out_keep_d = {B{1'b1}};
                    state_d    = SHIFT;
                end else if (total_s > KW'(B)) begin
                    out_keep_d  = {B{1'b1}};
                    out_last_d  = 1'b0;
                    flush_cnt_d = total_s - KW'(B);
                    state_d     = FLUSH;
                end else begin
                    out_keep_d = ones(total_s);
                    out_last_d = 1'b1;
                    state_d    = PRE;
                end
            end else if (!axis_in_tlast && (INS_BEAT > 0) && en_s &&
                         (beat_cnt_q == CW'(INS_BEAT - 1))) begin
                state_d = INS;
            end else begin
                state_d = PRE;
            end
        end else if (load_s) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State and output registers; async reset drops any partial packet.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= PRE;
            beat_cnt_q  <= {CW{1'b0}};
            carry_q     <= {(S*8){1'b0}};
            flush_cnt_q <= {KW{1'b0}};
            seg_q       <= {(S*8){1'b0}};
            en_q        <= 1'b0;
            user_q      <= {AXIS_TUSER_WIDTH{1'b0}};
            rdy_en_q    <= 1'b0;
            out_data_q  <= {AXIS_BUS_WIDTH{1'b0}};
            out_keep_q  <= {B{1'b0}};
            out_user_q  <= {AXIS_TUSER_WIDTH{1'b0}};
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_cnt_q  <= beat_cnt_d;
            carry_q     <= carry_d;
            flush_cnt_q <= flush_cnt_d;
            seg_q       <= seg_d;
            en_q        <= en_d;
            user_q      <= user_d;
            rdy_en_q    <= rdy_en_d;
            out_data_q  <= out_data_d;
            out_keep_q  <= out_keep_d;
            out_user_q  <= out_user_d;
            out_last_q  <= out_last_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign axis_in_tready  = in_ready_s;
    assign axis_out_tdata  = out_data_q;
    assign axis_out_tkeep  = out_keep_q;
    assign axis_out_tuser  = out_user_q;
    assign axis_out_tlast  = out_last_q;
    assign axis_out_tvalid = out_valid_q;

endmodule

// File: tb/tb_segment_inserter.sv
// Directed and randomized-backpressure bench for segment_inserter (B=8, O=12, S=4).
`timescale 1ns/1ps
module tb_segment_inserter;
    localparam int B = 8;
    localparam int O = 12;
    localparam int S = 4;

    logic        aclk, aresetn;
    logic [63:0] axis_in_tdata;
    logic [7:0]  axis_in_tkeep;
    logic [3:0]  axis_in_tuser;
    logic        axis_in_tlast, axis_in_tvalid, axis_in_tready;
    logic [63:0] axis_out_tdata;
    logic [7:0]  axis_out_tkeep;
    logic [3:0]  axis_out_tuser;
    logic        axis_out_tlast, axis_out_tvalid, axis_out_tready;
    logic [31:0] segment_data;
    logic        segment_enable;

    int checks, errors;
    bit rnd_ready;
    logic [7:0]  got_q[$];
    logic [3:0]  got_user_q[$];
    int          got_beats_q[$];
    int          got_nbytes_q[$];
    logic [7:0]  got_lkeep_q[$];
    logic [63:0] got_ldata_q[$];
    int          cur_beats, cur_nbytes;
    logic [7:0]  exp_q[$];
    logic [7:0]  pkt_q[$];
    logic [3:0]  pu_q[$];

    segment_inserter #(
        .AXIS_BUS_WIDTH(64), .AXIS_TUSER_WIDTH(4), .MAX_PACKET_LENGTH(1522),
        .INSERT_OFFSET(12), .INSERT_SIZE_BYTES(4)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .axis_in_tdata(axis_in_tdata), .axis_in_tkeep(axis_in_tkeep),
        .axis_in_tuser(axis_in_tuser), .axis_in_tlast(axis_in_tlast),
        .axis_in_tvalid(axis_in_tvalid), .axis_in_tready(axis_in_tready),
        .axis_out_tdata(axis_out_tdata), .axis_out_tkeep(axis_out_tkeep),
        .axis_out_tuser(axis_out_tuser), .axis_out_tlast(axis_out_tlast),
        .axis_out_tvalid(axis_out_tvalid), .axis_out_tready(axis_out_tready),
        .segment_data(segment_data), .segment_enable(segment_enable)
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    initial begin
        axis_out_tready = 1'b1;
        forever begin
            @(posedge aclk);
            #1;
            axis_out_tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    function automatic logic [7:0] pkt_byte(input int seed, input int k);
        return 8'(seed * 37 + k * 5 + (k >> 8));
    endfunction

    function automatic logic [7:0] keep_of(input int n);
        logic [7:0] m;
        for (int i = 0; i < 8; i++) m[i] = (i < n);
        return m;
    endfunction

    // Output monitor: collects accepted bytes per packet and checks stability under stall.
    initial begin
        logic held, hl;
        logic [63:0] hd;
        logic [7:0] hk;
        logic [3:0] hu;
        held = 1'b0; cur_beats = 0; cur_nbytes = 0;
        forever begin
            @(negedge aclk);
            if (!aresetn) begin
                held = 1'b0;
            end else begin
                if (held) begin
                    checks++;
                    if (axis_out_tvalid !== 1'b1 || axis_out_tdata !== hd || axis_out_tkeep !== hk ||
                        axis_out_tuser !== hu || axis_out_tlast !== hl) begin
                        errors++;
                        $display("FAIL stall_stable got v%0b d%h k%h want v1 d%h k%h", axis_out_tvalid,
                                 axis_out_tdata, axis_out_tkeep, hd, hk);
                    end
                end
                if (axis_out_tvalid && axis_out_tready) begin
                    for (int l = 0; l < 8; l++)
                        if (axis_out_tkeep[l]) begin got_q.push_back(axis_out_tdata[l*8 +: 8]); cur_nbytes++; end
                    got_user_q.push_back(axis_out_tuser);
                    cur_beats++;
                    if (axis_out_tlast) begin
                        got_beats_q.push_back(cur_beats); got_nbytes_q.push_back(cur_nbytes);
                        got_lkeep_q.push_back(axis_out_tkeep); got_ldata_q.push_back(axis_out_tdata);
                        cur_beats = 0; cur_nbytes = 0;
                    end
                    held = 1'b0;
                end else if (axis_out_tvalid) begin
                    held = 1'b1; hd = axis_out_tdata; hk = axis_out_tkeep; hu = axis_out_tuser; hl = axis_out_tlast;
                end else begin
                    held = 1'b0;
                end
            end
        end
    end

    task automatic send_pkt(input int len, input bit en, input logic [31:0] seg, input int seed,
                            input int abort_at, output int first_wait);
        int nin, n;
        bit ok;
        nin = (len + B - 1) / B;
        first_wait = 0;
        for (int b = 0; b < nin; b++) begin
            for (int l = 0; l < B; l++) axis_in_tdata[l*8 +: 8] = pkt_byte(seed, b * B + l);
            axis_in_tkeep  = (b == nin - 1) ? keep_of(len - b * B) : 8'hFF;
            axis_in_tlast  = (b == nin - 1);
            axis_in_tuser  = 4'(seed + b);
            axis_in_tvalid = 1'b1;
            segment_data   = (b == 0) ? seg : ~seg;
            segment_enable = (b == 0) ? en : ~en;
            if (b == abort_at) begin
                #2;
                aresetn = 1'b0;
                return;
            end
            n = 0;
            do begin
                @(negedge aclk);
                ok = axis_in_tready;
                if (!ok) n++;
                @(posedge aclk);
                #1;
            end while (!ok && n < 5000);
            if (!ok) begin
                checks++; errors++;
                $display("FAIL in_handshake timeout pkt seed %0d beat %0d", seed, b);
                axis_in_tvalid = 1'b0;
                return;
            end
            if (b == 0) first_wait = n;
        end
        axis_in_tvalid = 1'b0;
    endtask

    task automatic build_exp(input int len, input bit en, input logic [31:0] seg, input int seed);
        exp_q.delete();
        for (int k = 0; k < len; k++) begin
            if (en && len > O && k == O)
                for (int j = 0; j < S; j++) exp_q.push_back(seg[j*8 +: 8]);
            exp_q.push_back(pkt_byte(seed, k));
        end
    endtask

    task automatic wait_pkts(input int n);
        int t;
        t = 0;
        while (got_beats_q.size() < n && t < 50000) begin @(posedge aclk); t++; end
        #1;
        checks++;
        if (got_beats_q.size() < n) begin
            errors++;
            $display("FAIL pkt_count got %0d want %0d", got_beats_q.size(), n);
        end
    endtask

    task automatic pop_pkt(output int beats, output logic [7:0] lkeep, output logic [63:0] ldata);
        int nb;
        pkt_q.delete(); pu_q.delete();
        beats = 0; lkeep = 8'h00; ldata = 64'h0;
        if (got_beats_q.size() == 0) return;
        beats = got_beats_q.pop_front(); nb = got_nbytes_q.pop_front();
        lkeep = got_lkeep_q.pop_front(); ldata = got_ldata_q.pop_front();
        for (int i = 0; i < nb; i++) pkt_q.push_back(got_q.pop_front());
        for (int i = 0; i < beats; i++) pu_q.push_back(got_user_q.pop_front());
    endtask

    task automatic test_reset();
        aresetn = 1'b0; axis_in_tvalid = 1'b0; axis_in_tdata = 64'h0; axis_in_tkeep = 8'h00;
        axis_in_tuser = 4'h0; axis_in_tlast = 1'b0; segment_data = 32'h0; segment_enable = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        checks++; if (axis_out_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got %0b want 0", axis_out_tvalid); end
        checks++; if (axis_out_tdata !== 64'h0) begin errors++; $display("FAIL reset_tdata got %h want 0", axis_out_tdata); end
        checks++; if (axis_out_tkeep !== 8'h00) begin errors++; $display("FAIL reset_tkeep got %h want 0", axis_out_tkeep); end
        checks++; if (axis_out_tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast got %0b want 0", axis_out_tlast); end
        checks++; if (axis_out_tuser !== 4'h0) begin errors++; $display("FAIL reset_tuser got %h want 0", axis_out_tuser); end
        checks++; if (axis_in_tready !== 1'b0) begin errors++; $display("FAIL reset_tready got %0b want 0", axis_in_tready); end
        @(negedge aclk);
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        checks++; if (axis_in_tready !== 1'b1) begin errors++; $display("FAIL post_reset_tready got %0b want 1", axis_in_tready); end
    endtask

    task automatic test_insert();
        int fw, beats, bad;
        logic [7:0] lk;
        logic [63:0] ld;
        send_pkt(60, 1'b1, 32'hAABBCCDD, 1, -1, fw);
        wait_pkts(1);
        pop_pkt(beats, lk, ld);
        build_exp(60, 1'b1, 32'hAABBCCDD, 1);
        checks++; if (beats !== 8) begin errors++; $display("FAIL ins60_beats got %0d want 8", beats); end
        checks++; if (lk !== 8'hFF) begin errors++; $display("FAIL ins60_lastkeep got %h want ff", lk); end
        checks++; if (pkt_q.size() !== 64) begin errors++; $display("FAIL ins60_len got %0d want 64", pkt_q.size()); end
        if (pkt_q.size() >= 17) begin
            checks++;
            if ({pkt_q[15], pkt_q[14], pkt_q[13], pkt_q[12]} !== 32'hAABBCCDD) begin
                errors++; $display("FAIL ins60_seg got %h%h%h%h want aabbccdd", pkt_q[15], pkt_q[14], pkt_q[13], pkt_q[12]);
            end
            checks++;
            if (pkt_q[16] !== pkt_byte(1, 12)) begin errors++; $display("FAIL ins60_byte16 got %h want %h", pkt_q[16], pkt_byte(1, 12)); end
        end
        bad = (pkt_q.size() != exp_q.size()) ? 1 : 0;
        for (int i = 0; i < pkt_q.size() && i < exp_q.size(); i++) if (pkt_q[i] !== exp_q[i]) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL ins60_bytes got %0d bad bytes want 0", bad); end
        bad = 0;
        for (int j = 0; j < pu_q.size(); j++) if (pu_q[j] !== 4'(1 + j)) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL ins60_tuser got %0d bad beats want 0", bad); end
    endtask

    task automatic test_back_to_back();
        int fw0, fw1, beats, bad;
        logic [7:0] lk;
        logic [63:0] ld;
        send_pkt(60, 1'b1, 32'h01020304, 7, -1, fw0);
        send_pkt(60, 1'b1, 32'h05060708, 8, -1, fw1);
        checks++; if (fw1 !== 0) begin errors++; $display("FAIL b2b_first_wait got %0d want 0", fw1); end
        wait_pkts(2);
        for (int p = 0; p < 2; p++) begin
            pop_pkt(beats, lk, ld);
            build_exp(60, 1'b1, (p == 0) ? 32'h01020304 : 32'h05060708, 7 + p);
            bad = (pkt_q.size() != exp_q.size()) ? 1 : 0;
            for (int i = 0; i < pkt_q.size() && i < exp_q.size(); i++) if (pkt_q[i] !== exp_q[i]) bad++;
            checks++; if (bad != 0) begin errors++; $display("FAIL b2b_bytes pkt %0d got %0d bad want 0", p, bad); end
        end
    endtask

    task automatic test_flush();
        int fw0, fw1, beats, bad;
        logic [7:0] lk;
        logic [63:0] ld;
        send_pkt(64, 1'b1, 32'h11223344, 2, -1, fw0);
        send_pkt(60, 1'b1, 32'h55667788, 4, -1, fw1);
        checks++; if (fw1 !== 1) begin errors++; $display("FAIL flush_ready_gap got %0d stalls want 1", fw1); end
        wait_pkts(2);
        pop_pkt(beats, lk, ld);
        build_exp(64, 1'b1, 32'h11223344, 2);
        checks++; if (beats !== 9) begin errors++; $display("FAIL flush_beats got %0d want 9", beats); end
        checks++; if (lk !== 8'h0F) begin errors++; $display("FAIL flush_lastkeep got %h want 0f", lk); end
        checks++;
        if (ld[31:0] !== {pkt_byte(2, 63), pkt_byte(2, 62), pkt_byte(2, 61), pkt_byte(2, 60)}) begin
            errors++; $display("FAIL flush_data got %h want bytes 60..63", ld[31:0]);
        end
        bad = (pkt_q.size() != exp_q.size()) ? 1 : 0;
        for (int i = 0; i < pkt_q.size() && i < exp_q.size(); i++) if (pkt_q[i] !== exp_q[i]) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL flush_bytes got %0d bad want 0", bad); end
        checks++; if (pu_q.size() == 9 && pu_q[8] !== 4'(2 + 7)) begin errors++; $display("FAIL flush_tuser got %h want %h", pu_q[8], 4'(9)); end
        pop_pkt(beats, lk, ld);
        build_exp(60, 1'b1, 32'h55667788, 4);
        bad = (pkt_q.size() != exp_q.size()) ? 1 : 0;
        for (int i = 0; i < pkt_q.size() && i < exp_q.size(); i++) if (pkt_q[i] !== exp_q[i]) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL after_flush_bytes got %0d bad want 0", bad); end
    endtask

    task automatic test_passthrough();
        int fw, beats, bad;
        logic [7:0] lk;
        logic [63:0] ld, want;
        send_pkt(60, 1'b0, 32'hDEADBEEF, 3, -1, fw);
        wait_pkts(1);
        pop_pkt(beats, lk, ld);
        build_exp(60, 1'b0, 32'hDEADBEEF, 3);
        for (int l = 0; l < 8; l++) want[l*8 +: 8] = pkt_byte(3, 56 + l);
        checks++; if (beats !== 8) begin errors++; $display("FAIL pass_beats got %0d want 8", beats); end
        checks++; if (lk !== 8'h0F) begin errors++; $display("FAIL pass_lastkeep got %h want 0f", lk); end
        checks++; if (ld !== want) begin errors++; $display("FAIL pass_lastdata got %h want %h", ld, want); end
        bad = (pkt_q.size() != exp_q.size()) ? 1 : 0;
        for (int i = 0; i < pkt_q.size() && i < exp_q.size(); i++) if (pkt_q[i] !== exp_q[i]) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL pass_bytes got %0d bad want 0", bad); end
    endtask

    task automatic test_short();
        int fw, beats, bad;
        logic [7:0] lk;
        logic [63:0] ld;
        send_pkt(10, 1'b1, 32'hCAFEF00D, 9, -1, fw);
        wait_pkts(1);
        pop_pkt(beats, lk, ld);
        build_exp(10, 1'b1, 32'hCAFEF00D, 9);
        checks++; if (beats !== 2) begin errors++; $display("FAIL short_beats got %0d want 2", beats); end
        checks++; if (lk !== 8'h03) begin errors++; $display("FAIL short_lastkeep got %h want 03", lk); end
        bad = (pkt_q.size() != exp_q.size()) ? 1 : 0;
        for (int i = 0; i < pkt_q.size() && i < exp_q.size(); i++) if (pkt_q[i] !== exp_q[i]) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL short_bytes got %0d bad want 0", bad); end
    endtask

    task automatic test_random();
        int lens[100];
        bit ens[100];
        logic [31:0] segs[100];
        int fw, beats, bad, nin, wbeats;
        logic [7:0] lk;
        logic [63:0] ld;
        rnd_ready = 1'b1;
        for (int p = 0; p < 100; p++) begin
            lens[p] = $urandom_range(13, 1522);
            ens[p]  = 1'($urandom_range(0, 1));
            segs[p] = $urandom;
            send_pkt(lens[p], ens[p], segs[p], 100 + p, -1, fw);
        end
        wait_pkts(100);
        rnd_ready = 1'b0;
        for (int p = 0; p < 100; p++) begin
            pop_pkt(beats, lk, ld);
            build_exp(lens[p], ens[p], segs[p], 100 + p);
            nin = (lens[p] + 7) / 8;
            wbeats = (exp_q.size() + 7) / 8;
            bad = (pkt_q.size() != exp_q.size()) ? 1 : 0;
            for (int i = 0; i < pkt_q.size() && i < exp_q.size(); i++) if (pkt_q[i] !== exp_q[i]) bad++;
            for (int j = 0; j < pu_q.size(); j++) if (pu_q[j] !== 4'(100 + p + ((j < nin) ? j : nin - 1))) bad++;
            checks++;
            if (bad != 0 || beats != wbeats || lk !== keep_of(exp_q.size() - (wbeats - 1) * 8)) begin
                errors++;
                $display("FAIL rand_pkt %0d len %0d en %0b got %0d bad beats %0d keep %h want 0 bad beats %0d", p,
                         lens[p], ens[p], bad, beats, lk, wbeats);
            end
        end
    endtask

    task automatic test_reset_mid();
        int fw, beats, bad;
        logic [7:0] lk;
        logic [63:0] ld;
        send_pkt(60, 1'b1, 32'h99887766, 5, 3, fw);
        #1;
        checks++; if (axis_out_tvalid !== 1'b0) begin errors++; $display("FAIL midrst_tvalid got %0b want 0", axis_out_tvalid); end
        checks++; if (axis_in_tready !== 1'b0) begin errors++; $display("FAIL midrst_tready got %0b want 0", axis_in_tready); end
        axis_in_tvalid = 1'b0;
        got_q.delete(); got_user_q.delete(); cur_beats = 0; cur_nbytes = 0;
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        send_pkt(60, 1'b1, 32'h11223344, 6, -1, fw);
        wait_pkts(1);
        pop_pkt(beats, lk, ld);
        build_exp(60, 1'b1, 32'h11223344, 6);
        checks++; if (beats !== 8) begin errors++; $display("FAIL midrst_beats got %0d want 8", beats); end
        if (pkt_q.size() >= 16) begin
            checks++;
            if ({pkt_q[15], pkt_q[14], pkt_q[13], pkt_q[12]} !== 32'h11223344) begin
                errors++; $display("FAIL midrst_seg got %h%h%h%h want 11223344", pkt_q[15], pkt_q[14], pkt_q[13], pkt_q[12]);
            end
        end
        bad = (pkt_q.size() != exp_q.size()) ? 1 : 0;
        for (int i = 0; i < pkt_q.size() && i < exp_q.size(); i++) if (pkt_q[i] !== exp_q[i]) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL midrst_bytes got %0d bad want 0", bad); end
    endtask

    initial begin
        checks = 0; errors = 0; rnd_ready = 1'b0;
        test_reset();
        test_insert();
        test_back_to_back();
        test_flush();
        test_passthrough();
        test_short();
        test_random();
        test_reset_mid();
        repeat (4) @(posedge aclk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/segment_inserter.md
Name: segment_inserter

Overview:
- Streaming AXI4-Stream block that inserts a fixed-size byte segment at a fixed byte offset into each packet, e.g. a 4-byte VLAN tag after the MAC addresses.
- It is the TX-side counterpart of the segment remover in the NMU datapath. Its output feeds the egress network port.
- Per-packet insertion is enabled or disabled and the segment contents are supplied per packet. A carry register absorbs the byte shift and emits an extra flush beat when needed.

Parameters:
- AXIS_BUS_WIDTH, 64, data width in bits; multiple of 16.
- AXIS_TUSER_WIDTH, 4, tuser width.
- MAX_PACKET_LENGTH, 1522, max input packet bytes; sizes the beat counter.
- INSERT_OFFSET, 12, byte index of the first inserted byte; even.
- INSERT_SIZE_BYTES, 4, inserted bytes; even, 2..AXIS_BUS_WIDTH/8.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  asynchronous active-low reset.
- axis_in_tdata  in  AXIS_BUS_WIDTH  input data, byte 0 in bits [7:0].
- axis_in_tkeep  in  AXIS_BUS_WIDTH/8  contiguous from LSB; partial only on the last beat.
- axis_in_tuser  in  AXIS_TUSER_WIDTH  sideband.
- axis_in_tlast  in  1  end of packet.
- axis_in_tvalid  in  1  input valid.
- axis_in_tready  out  1  input ready.
- axis_out_tdata  out  AXIS_BUS_WIDTH  output data.
- axis_out_tkeep  out  AXIS_BUS_WIDTH/8  output keep.
- axis_out_tuser  out  AXIS_TUSER_WIDTH  output sideband.
- axis_out_tlast  out  1  end of packet.
- axis_out_tvalid  out  1  output valid.
- axis_out_tready  in  1  output ready.
- segment_data  in  INSERT_SIZE_BYTES*8  segment; byte 0 in bits [7:0] goes to output byte INSERT_OFFSET.
- segment_enable  in  1  1 = insert into this packet.

Behaviour:
- Clock/reset: aclk is the only clock. aresetn is asynchronous, active low.
- Reset values:
  - axis_out_tvalid=0, axis_out_tlast=0, axis_out_tdata=0, axis_out_tkeep=0, axis_out_tuser=0.
  - axis_in_tready=0 while aresetn is low, then follows the ready rule.
  - FSM goes to PRE, beat counter=0, carry cleared.
- Sampling: segment_data and segment_enable are sampled on the first-beat handshake of each packet and held internally until tlast is accepted.
- Byte map, input length L, bus bytes B, S=INSERT_SIZE_BYTES, O=INSERT_OFFSET (insertion on, L>O):
  - out[i]=in[i] for i<O.
  - out[i]=seg[i-O] for O<=i<O+S.
  - out[i]=in[i-S] for i>=O+S.
  - Output length L+S; output beats = ceil((L+S)/B).
- Pass-through: segment_enable=0, or L<=O (tlast arrives at or before byte O). The packet passes bit-identical, same beats and tkeep.
- Output register: one output register stage; latency input handshake to axis_out_tvalid is 1 cycle.
  - The register loads when it is empty or axis_out_tready=1.
  - axis_out_* are held stable while tvalid=1 and tready=0.
- Ready rule: axis_in_tready = (!axis_out_tvalid || axis_out_tready) && state!=FLUSH.
- States:
  - PRE: beats before the insertion beat; pass-through. The insertion beat is beat index O/B, lane O%B.
  - INS: on the insertion-beat handshake:
    - bytes below lane O%B pass through, then S segment bytes, then input bytes shifted up by S;
    - the top S input bytes of the beat go to the carry register (as many as are valid).
    - If that beat is also tlast, go to FLUSH when the carry holds valid bytes, else to PRE.
    - Otherwise go to SHIFT.
  - SHIFT: output = {in[B-S-1:0], carry}; carry <= in[B-1:B-S].
    - On tlast: if the count of valid shifted bytes beyond the beat (tkeep popcount + S - B) is >0, go to FLUSH with out_tlast=0.
    - Else out_tlast=1, tkeep = popcount+S ones, go to PRE.
  - FLUSH: emit carry bytes alone; tkeep = low (popcount+S-B) ones; tlast=1; tuser from the last input beat. Input is not accepted. On output accept go to PRE.
- tuser: each output beat carries the tuser of the input beat that produced it.
- Beat counter: width $clog2(MAX_PACKET_LENGTH/B+2). It saturates and clears at tlast.
- Back-to-back packets: the next packet's first beat is accepted in the cycle after the last beat or flush beat is loaded; no dead cycle when not flushing.
- Reset mid-packet: the partial packet is discarded, outputs go to reset values, and the next beat after reset is treated as a first beat.

Test Plan:
- B=8, O=12, S=4; 60B packet (last tkeep 0x0F), enable=1, seg=0xAABBCCDD -> 8 beats. Out bytes 12..15 = DD CC BB AA; byte 16 = in byte 12; last tkeep 0xFF; no flush beat.
- 64B packet, enable=1 -> 9 beats. Beat 8 tkeep 0x0F holds in bytes 60..63 with tlast=1; axis_in_tready=0 during the flush cycle; the next packet starts the following cycle.
- 60B packet, enable=0 -> output bit-identical to input: 8 beats, last tkeep 0x0F.
- 10B packet (L<=O), enable=1 -> passes unchanged: 2 beats, tkeep 0xFF then 0x03.
- Random axis_out_tready (50%) over 100 mixed packets of 13..1522B -> output equals the golden byte map with no loss or duplication; axis_out_* stable while stalled.
- Assert aresetn low during beat 3 of a packet -> same cycle axis_out_tvalid=0; after release the next packet is inserted correctly at byte 12.
